// File: rtl/apb2wb_bridge_reg.sv
// Registered APB4 to classic Wishbone bridge: one WB transfer per APB access.
// Optional wait-state timeout enabled by defining APB2WB_TIMEOUT_EN.
module apb2wb_bridge_reg #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [2:0]              PPROT,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic                    cyc,
    output logic                    stb,
    output logic                    we,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    ack,
    input  logic                    err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic                    cyc_d, we_d, pready_d, pslverr_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_o_d, prdata_d;
    logic [STRB_WIDTH-1:0]   sel_d;

`ifdef APB2WB_TIMEOUT_EN
    // Counts REQ cycles already spent without ack/err; max value is TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
`endif

    // PPROT is reserved; TIMEOUT_CYCLES is folded in so the plain build has no dangling parameter.
    logic unused_ok;
    assign unused_ok = ^{PPROT, 32'(TIMEOUT_CYCLES)};

    // Next-state and next-register values.
    always_comb begin
        state_d   = state;
        cyc_d     = cyc;
        we_d      = we;
        addr_d    = addr;
        data_o_d  = data_o;
        sel_d     = sel;
        prdata_d  = PRDATA;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
`ifdef APB2WB_TIMEOUT_EN
        wait_cnt_d = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d   = PADDR;
                    we_d     = PWRITE;
                    data_o_d = PWDATA;
                    sel_d    = PWRITE ? PSTRB : {STRB_WIDTH{1'b1}};
                    if (PWRITE && (PSTRB == '0)) begin
                        // Null write: answer directly without touching Wishbone.
                        state_d  = RESP;
                        pready_d = 1'b1;
                    end else begin
                        cyc_d   = 1'b1;
                        state_d = REQ;
`ifdef APB2WB_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (err) begin
                    cyc_d     = 1'b0;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    pready_d  = 1'b1;
                    state_d   = RESP;
                end else if (ack) begin
                    cyc_d    = 1'b0;
                    pready_d = 1'b1;
                    state_d  = RESP;
                    if (!we) begin
                        prdata_d = data_i;
                    end
`ifdef APB2WB_TIMEOUT_EN
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d     = 1'b0;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    pready_d  = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // Register bank with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            data_o  <= '0;
            sel     <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
`ifdef APB2WB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state   <= state_d;
            cyc     <= cyc_d;
            stb     <= cyc_d;
            we      <= we_d;
            addr    <= addr_d;
            data_o  <= data_o_d;
            sel     <= sel_d;
            PRDATA  <= prdata_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
`ifdef APB2WB_TIMEOUT_EN
            wait_cnt <= wait_cnt_d;
`endif
        end
    end

endmodule
